ledshift_game_ctrl: RTL and testbench

//   Round sequencer/scorer for the 16-LED shift bar. Drives the shifter's en level:
//   low reloads the bar to all-ones, high shifts it right once per clk.

---
 rtl/ledshift_game_ctrl.sv | 150 +++++++++++++++
 tb/tb_ledshift_game_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledshift_game_ctrl.sv
// Round sequencer and scorer for the 16-LED shift bar: runs timed rounds, judges the
// button against the shifter's readin window flag, and tracks score and lives.
module ledshift_game_ctrl #(
  parameter int STEPS      = 17,
  parameter int GAP_CYCLES = 4,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8,
  localparam int LW        = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               btn,
  input  logic               readin_i,
  output logic               shift_en,
  output logic [SCORE_W-1:0] score,
  output logic [LW-1:0]      lives,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               busy,
  output logic               game_over
);

  localparam int SCW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SCW-1:0] LAST_STEP  = SCW'(STEPS - 1);
  localparam logic [GCW-1:0] LAST_GAP   = GCW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0]  LIVES_INIT = LW'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RESULT,
    S_GAP,
    S_OVER
  } state_t;

  state_t             r_state;
  logic               r_start_q;
  logic               r_btn_q;
  logic [SCW-1:0]     r_step_cnt;
  logic [GCW-1:0]     r_gap_cnt;
  logic               r_shift_en;
  logic [SCORE_W-1:0] r_score;
  logic [LW-1:0]      r_lives;
  logic               r_hit;
  logic               r_miss;
  logic               r_busy;
  logic               r_game_over;

  logic w_start_edge;
  logic w_press;
  logic w_score_max;
  logic w_judge;

  // btn_q tracks btn in every state, so a button held into RUN never reads as a press.
  assign w_start_edge = start & ~r_start_q;
  assign w_press      = btn & ~r_btn_q;
  assign w_score_max  = &r_score;
  assign w_judge      = w_press | (r_step_cnt == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start_q   <= 1'b0;
      r_btn_q     <= 1'b0;
      r_step_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_shift_en  <= 1'b0;
      r_score     <= '0;
      r_lives     <= LIVES_INIT;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_busy      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_start_q <= start;
      r_btn_q   <= btn;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            r_score     <= '0;
            r_lives     <= LIVES_INIT;
            r_step_cnt  <= '0;
            r_shift_en  <= 1'b1;
            r_busy      <= 1'b1;
            r_game_over <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_judge) begin
            r_shift_en <= 1'b0;
            r_state    <= S_RESULT;
            // A press on the last step is still judged by readin_i, not as a timeout.
            if (w_press && !readin_i) begin
              r_hit <= 1'b1;
              if (!w_score_max) begin
                r_score <= r_score + 1'b1;
              end
            end else begin
              r_miss <= 1'b1;
              if (r_lives != '0) begin
                r_lives <= r_lives - 1'b1;
              end
            end
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        S_RESULT: begin
          if (r_lives == '0) begin
            r_busy      <= 1'b0;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_gap_cnt <= '0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == LAST_GAP) begin
            r_step_cnt <= '0;
            r_shift_en <= 1'b1;
            r_state    <= S_RUN;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_shift_en  <= 1'b0;
          r_busy      <= 1'b0;
          r_game_over <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign shift_en   = r_shift_en;
  assign score      = r_score;
  assign lives      = r_lives;
  assign hit_pulse  = r_hit;
  assign miss_pulse = r_miss;
  assign busy       = r_busy;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_ledshift_game_ctrl.sv
// Bench for ledshift_game_ctrl: two controllers (8-bit and 2-bit score) each driving a
// 16-bit shift bar, checked every cycle against a round-level game model.
module tb_ledshift_game_ctrl;

  localparam int STEPS = 17;
  localparam int GAP   = 4;
  localparam int LIVES = 3;
  localparam int BAR   = 16;

  localparam int P_IDLE = 0, P_RUN = 1, P_RES = 2, P_GAP = 3, P_OVER = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic btn = 1'b0;

  logic       shift_en_a, readin_a, hit_a, miss_a, busy_a, over_a;
  logic [7:0] score_a;
  logic [1:0] lives_a;
  logic       shift_en_b, readin_b, hit_b, miss_b, busy_b, over_b;
  logic [1:0] score_b;
  logic [1:0] lives_b;

  logic [BAR-1:0] led_a, led_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ledshift_game_ctrl #(.STEPS(STEPS), .GAP_CYCLES(GAP), .LIVES(LIVES), .SCORE_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .readin_i(readin_a),
    .shift_en(shift_en_a), .score(score_a), .lives(lives_a), .hit_pulse(hit_a),
    .miss_pulse(miss_a), .busy(busy_a), .game_over(over_a)
  );

  ledshift_game_ctrl #(.STEPS(STEPS), .GAP_CYCLES(GAP), .LIVES(LIVES), .SCORE_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .readin_i(readin_b),
    .shift_en(shift_en_b), .score(score_b), .lives(lives_b), .hit_pulse(hit_b),
    .miss_pulse(miss_b), .busy(busy_b), .game_over(over_b)
  );

  // 16-LED shifter: en low reloads all-ones, en high shifts right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_a <= '1;
      led_b <= '1;
    end else begin
      led_a <= shift_en_a ? (led_a >> 1) : '1;
      led_b <= shift_en_b ? (led_b >> 1) : '1;
    end
  end
  assign readin_a = (led_a[1:0] == 2'b11);
  assign readin_b = (led_b[1:0] == 2'b11);

  // Game model: phase, cycles spent in the current run, and round outcome.
  int m_phase = P_IDLE;
  int m_run_c = 0;
  int m_gap_c = 0;
  int m_score = 0;
  int m_lives = LIVES;
  bit m_hit   = 1'b0;
  bit m_btn_q = 1'b0;
  bit m_start_q = 1'b0;
  bit m_ready = 1'b0;
  bit m_press, m_sedge;

  task automatic m_resolve(input bit hit);
    m_hit   = hit;
    m_phase = P_RES;
    if (hit) m_score++;
    else if (m_lives > 0) m_lives--;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = P_IDLE; m_run_c = 0; m_gap_c = 0; m_score = 0; m_lives = LIVES;
      m_hit = 1'b0; m_btn_q = 1'b0; m_start_q = 1'b0;
    end else begin
      m_press = btn && !m_btn_q;
      m_sedge = start && !m_start_q;
      m_btn_q = btn;
      m_start_q = start;
      case (m_phase)
        P_IDLE, P_OVER: if (m_sedge) begin
          m_score = 0; m_lives = LIVES; m_run_c = 0; m_phase = P_RUN;
        end
        // After c shifts the bar holds BAR-c ones; the window is reached once fewer than two remain.
        P_RUN: begin
          if (m_press) m_resolve((BAR - m_run_c) < 2);
          else if (m_run_c == STEPS - 1) m_resolve(1'b0);
          else m_run_c++;
        end
        P_RES: begin
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_phase = P_GAP; m_gap_c = 0; end
        end
        P_GAP: begin
          if (m_gap_c == GAP - 1) begin m_phase = P_RUN; m_run_c = 0; end
          else m_gap_c++;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      check("shift_en", 32'(shift_en_a), 32'(m_phase == P_RUN));
      check("busy", 32'(busy_a), 32'(m_phase == P_RUN || m_phase == P_RES || m_phase == P_GAP));
      check("game_over", 32'(over_a), 32'(m_phase == P_OVER));
      check("hit_pulse", 32'(hit_a), 32'(m_phase == P_RES && m_hit));
      check("miss_pulse", 32'(miss_a), 32'(m_phase == P_RES && !m_hit));
      check("score", 32'(score_a), 32'(sat(m_score, 255)));
      check("lives", 32'(lives_a), 32'(m_lives));
      check("score_w2", 32'(score_b), 32'(sat(m_score, 3)));
      check("lives_w2", 32'(lives_b), 32'(m_lives));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_run(input string tag);
    int t;
    t = 0;
    while (!(m_phase == P_RUN && m_run_c == 0) && t < 100) begin
      cyc(1);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no round start within %0d cycles", tag, t);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    m_ready = 1'b1;
    cyc(10);
    check("idle_shift_en", 32'(shift_en_a), 0);
    check("idle_score", 32'(score_a), 0);
    check("idle_lives", 32'(lives_a), 3);
    check("idle_busy", 32'(busy_a), 0);
    check("idle_over", 32'(over_a), 0);

    // Hit in run cycle 15.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_run("hit_round");
    cyc(15);
    btn = 1'b1;
    cyc(1);
    check("hit_pulse_d", 32'(hit_a), 1);
    check("hit_score_d", 32'(score_a), 1);
    check("hit_lives_d", 32'(lives_a), 3);
    btn = 1'b0;
    cyc(1);
    check("hit_pulse_end", 32'(hit_a), 0);

    // Early press in run cycle 3.
    wait_run("early_round");
    cyc(3);
    btn = 1'b1;
    cyc(1);
    check("early_miss_d", 32'(miss_a), 1);
    check("early_lives_d", 32'(lives_a), 2);
    check("early_score_d", 32'(score_a), 1);
    btn = 1'b0;

    // Timeout round.
    wait_run("timeout_round");
    cyc(16);
    check("timeout_last_step_en", 32'(shift_en_a), 1);
    cyc(1);
    check("timeout_miss_d", 32'(miss_a), 1);
    check("timeout_lives_d", 32'(lives_a), 1);

    // Button held through the gap into the next run: no press, round times out.
    btn = 1'b1;
    wait_run("held_round");
    cyc(16);
    check("held_no_judge", 32'(shift_en_a), 1);
    cyc(1);
    check("held_miss_d", 32'(miss_a), 1);
    check("held_lives_d", 32'(lives_a), 0);
    btn = 1'b0;
    cyc(1);
    check("over_flag_d", 32'(over_a), 1);
    check("over_shift_en_d", 32'(shift_en_a), 0);
    cyc(3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("restart_score_d", 32'(score_a), 0);
    check("restart_lives_d", 32'(lives_a), 3);
    check("restart_busy_d", 32'(busy_a), 1);

    // Five hits: the 2-bit score saturates at 3.
    for (int i = 0; i < 5; i++) begin
      wait_run("hit_series");
      cyc(15);
      btn = 1'b1;
      cyc(1);
      btn = 1'b0;
      check("series_hit_d", 32'(hit_a), 1);
    end
    check("series_score_d", 32'(score_a), 5);
    check("series_score_w2_d", 32'(score_b), 3);

    // Asynchronous reset in the middle of a run.
    wait_run("rst_round");
    cyc(5);
    rst = 1'b1;
    #1;
    check("rst_shift_en_d", 32'(shift_en_a), 0);
    check("rst_score_d", 32'(score_a), 0);
    check("rst_lives_d", 32'(lives_a), 3);
    check("rst_pulses_d", 32'({hit_a, miss_a}), 0);
    check("rst_busy_d", 32'(busy_a), 0);
    check("rst_over_d", 32'(over_a), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Random play, biased so presses often land near the window.
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == P_RUN && m_run_c >= 13) begin
        if ($urandom_range(0, 2) == 0) btn = ~btn;
      end else if ($urandom_range(0, 7) == 0) begin
        btn = ~btn;
      end
      if (m_phase == P_IDLE || m_phase == P_OVER) begin
        if ($urandom_range(0, 3) == 0) start = ~start;
      end else if ($urandom_range(0, 29) == 0) begin
        start = ~start;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
